// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative multiply/divide engine for the HI/LO datapath.
//               It handles unsigned and signed multiply (shift-add) and
//               unsigned and signed divide (restoring), one bit per clock,
//               behind a start/busy/done handshake. A divide by zero is
//               reported on div_by_zero.
//
// Ports       :
//   clk          in   1      system clock, rising edge
//   rst          in   1      asynchronous reset, active low
//   start        in   1      request pulse, sampled only when idle
//   op           in   2      00 MULU, 01 MUL, 10 DIVU, 11 DIV
//   a_in         in   WIDTH  multiplicand / dividend
//   b_in         in   WIDTH  multiplier / divisor
//   busy         out  1      operation in progress
//   done         out  1      one-cycle pulse, results valid from here on
//   hi_out       out  WIDTH  MUL: product high half, DIV: remainder
//   lo_out       out  WIDTH  MUL: product low half,  DIV: quotient
//   div_by_zero  out  1      last DIV had a zero divisor
//
// Revision    : 1.0  initial release
// ============================================================================
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             div_by_zero
);

  localparam int             CW        = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  LAST_ITER = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 div_q, div_d;          // operation is a divide
  logic                 dbz_pend_q, dbz_pend_d; // zero divisor detected at start
  logic                 neg_quo_q, neg_quo_d;  // negate product / quotient
  logic                 neg_rem_q, neg_rem_d;  // negate remainder
  logic [WIDTH-1:0]     a_q, a_d;              // multiplicand magnitude, or raw dividend on /0
  logic [WIDTH-1:0]     b_q, b_d;              // divisor magnitude
  logic [2*WIDTH-1:0]   acc_q, acc_d;          // MUL accumulator / DIV dividend+quotient
  logic [WIDTH-1:0]     rem_q, rem_d;          // DIV remainder (always < divisor)
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 dbz_q, dbz_d;

  // --------------------------------------------------------------------------
  // Operand conditioning at start
  // --------------------------------------------------------------------------
  logic             w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;

  assign w_a_neg = op[0] & a_in[WIDTH-1];
  assign w_b_neg = op[0] & b_in[WIDTH-1];
  // The most-negative value maps onto itself, which read unsigned is the
  // correct magnitude 2**(WIDTH-1).
  assign w_a_mag = w_a_neg ? -a_in : a_in;
  assign w_b_mag = w_b_neg ? -b_in : b_in;

  // --------------------------------------------------------------------------
  // Multiply step: add multiplicand into the high half when the current
  // multiplier bit (acc LSB) is set, then shift the whole accumulator right.
  // The carry out of the add becomes the new MSB.
  // --------------------------------------------------------------------------
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;

  assign w_mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
  assign w_mul_next = {w_mul_sum, acc_q[WIDTH-1:1]};

  // --------------------------------------------------------------------------
  // Restoring divide step: shift the next dividend bit into the partial
  // remainder (WIDTH+1 bits wide) and subtract the divisor if it fits.
  // When it fits the true difference is below the divisor, so WIDTH bits of
  // the modular subtraction are exact.
  // --------------------------------------------------------------------------
  logic [WIDTH:0]     w_part;
  logic               w_fits;
  logic [WIDTH-1:0]   w_diff;
  logic [2*WIDTH-1:0] w_div_next;

  assign w_part     = {rem_q, acc_q[WIDTH-1]};
  assign w_fits     = (w_part >= {1'b0, b_q});
  assign w_diff     = w_part[WIDTH-1:0] - b_q;
  assign w_div_next = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], w_fits};

  // --------------------------------------------------------------------------
  // Sign fix-up
  // --------------------------------------------------------------------------
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  assign w_prod = neg_quo_q ? -acc_q : acc_q;
  assign w_quo  = neg_quo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign w_rem  = neg_rem_q ? -rem_q : rem_q;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    dbz_pend_d = dbz_pend_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    hi_d       = hi_q;
    lo_d       = lo_q;
    dbz_d      = dbz_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          div_d     = op[1];
          neg_quo_d = w_a_neg ^ w_b_neg;
          neg_rem_d = w_a_neg;
          b_d       = w_b_mag;
          rem_d     = '0;
          cnt_d     = '0;
          dbz_d     = 1'b0;
          busy_d    = 1'b1;
          if (op[1] && (b_in == '0)) begin
            // Nothing to iterate: report straight from FIX with the raw dividend.
            dbz_pend_d = 1'b1;
            a_d        = a_in;
            state_d    = S_FIX;
          end else begin
            dbz_pend_d = 1'b0;
            a_d        = w_a_mag;
            acc_d      = op[1] ? {{WIDTH{1'b0}}, w_a_mag} : {{WIDTH{1'b0}}, w_b_mag};
            state_d    = S_RUN;
          end
        end
      end

      S_RUN: begin
        if (div_q) begin
          acc_d = w_div_next;
          rem_d = w_fits ? w_diff : w_part[WIDTH-1:0];
        end else begin
          acc_d = w_mul_next;
        end
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == LAST_ITER) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (dbz_pend_q) begin
          hi_d  = a_q;
          lo_d  = '1;
          dbz_d = 1'b1;
        end else if (div_q) begin
          hi_d = w_rem;
          lo_d = w_quo;
        end else begin
          hi_d = w_prod[2*WIDTH-1:WIDTH];
          lo_d = w_prod[WIDTH-1:0];
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      div_q      <= 1'b0;
      dbz_pend_q <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      dbz_pend_q <= dbz_pend_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      dbz_q      <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hi_out      = hi_q;
  assign lo_out      = lo_q;
  assign div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Self-checking bench for muldiv_unit (WIDTH = 32). A
//               latency-level reference model computes results with plain
//               integer arithmetic; a compare process checks every cycle and
//               directed operations check hand-computed literal results.
// Revision    : 1.0  initial release
// ============================================================================
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi_out, lo_out;

  int n_tests = 0;
  int n_fail  = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .a_in        (a_in),
    .b_in        (b_in),
    .busy        (busy),
    .done        (done),
    .hi_out      (hi_out),
    .lo_out      (lo_out),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: arithmetic result and a latency countdown
  // --------------------------------------------------------------------------
  function automatic logic [2*W:0] ref_result(input logic [1:0] o, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    longint           sa, sb, q, r;
    logic [2*W-1:0]   p;
    logic [2*W:0]     res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!o[1]) begin
      if (o[0]) p = sa * sb;
      else      p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      res = {1'b0, p};
    end else if (b == '0) begin
      res = {1'b1, a, {W{1'b1}}};
    end else if (o[0]) begin
      q = sa / sb;
      r = sa % sb;
      res = {1'b0, r[W-1:0], q[W-1:0]};
    end else begin
      res = {1'b0, a % b, a / b};
    end
    return res;
  endfunction

  logic         m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0;
  logic [W-1:0] m_hi = '0, m_lo = '0;
  logic [2*W:0] m_pend = '0;
  int           m_left = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_dbz <= 1'b0;
      m_hi   <= '0;   m_lo   <= '0;   m_left <= 0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        {m_dbz, m_hi, m_lo} <= m_pend;
      end
    end else begin
      m_done <= 1'b0;
      if (start) begin
        m_pend <= ref_result(op, a_in, b_in);
        m_left <= (op[1] && b_in == '0) ? 1 : W + 1;
        m_busy <= 1'b1;
        m_dbz  <= 1'b0;
      end
    end
  end

  // Cycle-by-cycle comparison, away from the active edge
  always @(negedge clk) begin
    check("cyc_busy", {63'b0, busy}, {63'b0, m_busy});
    check("cyc_done", {63'b0, done}, {63'b0, m_done});
    check("cyc_hi",   {32'b0, hi_out}, {32'b0, m_hi});
    check("cyc_lo",   {32'b0, lo_out}, {32'b0, m_lo});
    check("cyc_dbz",  {63'b0, div_by_zero}, {63'b0, m_dbz});
    check("busy_and_done", {63'b0, busy & done}, 64'd0);
  end

  // --------------------------------------------------------------------------
  // Directed operation: called #1 after a rising edge with the unit idle (or
  // in its done cycle). Injects an ignored DIV start at edge inj_at if >= 0.
  // --------------------------------------------------------------------------
  task automatic do_op(input string nm, input logic [1:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el,
                       input logic ed, input int elat, input int inj_at);
    int edges;
    int busy_cnt;
    op = o; a_in = a; b_in = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a_in = $urandom; b_in = $urandom; op = 2'($urandom_range(0, 3));
    check({nm, "_dbz_cleared"}, {63'b0, div_by_zero}, 64'd0);
    edges = 0;
    busy_cnt = (busy === 1'b1) ? 1 : 0;
    while (done !== 1'b1 && edges < 200) begin
      if (edges == inj_at) begin
        start = 1'b1; op = 2'b10; a_in = 32'd9; b_in = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); edges++; #1;
      if (done !== 1'b1 && busy === 1'b1) busy_cnt++;
    end
    start = 1'b0;
    check({nm, "_done_seen"}, {63'b0, done}, 64'd1);
    check({nm, "_latency"}, 64'(edges), 64'(elat));
    check({nm, "_busy_cycles"}, 64'(busy_cnt), 64'(elat));
    check({nm, "_busy_low_at_done"}, {63'b0, busy}, 64'd0);
    check({nm, "_hi"}, {32'b0, hi_out}, {32'b0, eh});
    check({nm, "_lo"}, {32'b0, lo_out}, {32'b0, el});
    check({nm, "_dbz"}, {63'b0, div_by_zero}, {63'b0, ed});
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_done", {63'b0, done}, 64'd0);
    check("rst_hi", {32'b0, hi_out}, 64'd0);
    check("rst_lo", {32'b0, lo_out}, 64'd0);
    check("rst_dbz", {63'b0, div_by_zero}, 64'd0);
    #2 rst = 1'b1;
    @(posedge clk); #1;

    // Multiplies; each subsequent op starts in the previous done cycle
    do_op("mulu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33, -1);
    do_op("mul_m3x7", 2'b01, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33, -1);
    do_op("mulu_m3x7", 2'b00, 32'hFFFFFFFD, 32'd7, 32'h00000006, 32'hFFFFFFEB, 1'b0, 33, -1);

    // Divides
    do_op("div_m7d2", 2'b11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33, -1);
    do_op("div_7dm2", 2'b11, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 33, -1);
    do_op("div_m7dm2", 2'b11, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0, 33, -1);
    do_op("div_minneg", 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33, -1);
    do_op("divu_100d7", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33, -1);

    // Divide by zero, unsigned and signed (raw dividend returned)
    @(posedge clk); #1;
    do_op("divu_by0", 2'b10, 32'h00001234, 32'd0, 32'h00001234, 32'hFFFFFFFF, 1'b1, 1, -1);
    do_op("div_by0", 2'b11, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, 1, -1);

    // Start while busy is ignored; this accepted start also clears div_by_zero
    do_op("mul_ignore", 2'b00, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0, 33, 10);

    // Asynchronous reset mid-run
    repeat (2) @(posedge clk); #1;
    op = 2'b00; a_in = 32'h12345678; b_in = 32'h9ABCDEF0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("arst_busy", {63'b0, busy}, 64'd0);
    check("arst_done", {63'b0, done}, 64'd0);
    check("arst_hi", {32'b0, hi_out}, 64'd0);
    check("arst_lo", {32'b0, lo_out}, 64'd0);
    check("arst_dbz", {63'b0, div_by_zero}, 64'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    repeat (25) begin
      @(posedge clk); #1;
      check("arst_no_done", {63'b0, done}, 64'd0);
    end
    do_op("mul_after_rst", 2'b00, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 33, -1);

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
